// File: rtl/machine_scheduler_pkg.sv
// Shared types, constants and saturating-add helpers for machine_scheduler.
package machine_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned DEF_MAX_NUM_BUTTONS = 32'd13;
  localparam int unsigned DEF_PRESSES_W       = $clog2(DEF_MAX_NUM_BUTTONS + 32'd1);
  localparam logic [DEF_PRESSES_W-1:0] NO_SOLUTION = {DEF_PRESSES_W{1'b1}};

  // Adds a and b, clamping the result to the largest w-bit value.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic logic sat_hit(input logic [31:0] a, input logic [31:0] b,
                                   input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim);
  endfunction

endpackage

// File: rtl/machine_scheduler_if.sv
// Descriptor stream and solver handshake bundle; master = scheduler, slave = parser/solver side.
interface machine_scheduler_if #(
  parameter int unsigned MAX_NUM_LIGHTS    = 32'd10,
  parameter int unsigned MAX_NUM_BUTTONS   = 32'd13,
  parameter int unsigned MAX_NUM_LIGHTS_W  = $clog2(MAX_NUM_LIGHTS + 32'd1),
  parameter int unsigned MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 32'd1)
);
  logic                                   in_valid;
  logic                                   in_ready;
  logic                                   in_last;
  logic [MAX_NUM_LIGHTS_W-1:0]            in_num_lights;
  logic [MAX_NUM_BUTTONS_W-1:0]           in_num_buttons;
  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] in_buttons;
  logic [MAX_NUM_LIGHTS-1:0]              in_target;

  logic [MAX_NUM_LIGHTS_W-1:0]            cm_num_lights;
  logic [MAX_NUM_BUTTONS_W-1:0]           cm_num_buttons;
  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] cm_buttons;
  logic [MAX_NUM_LIGHTS-1:0]              cm_target;
  logic                                   cm_start;
  logic                                   cm_ready;
  logic                                   cm_accepted;
  logic [MAX_NUM_BUTTONS_W-1:0]           cm_min_presses;

  modport master (
    input  in_valid, in_last, in_num_lights, in_num_buttons, in_buttons, in_target,
    input  cm_ready, cm_min_presses,
    output in_ready, cm_num_lights, cm_num_buttons, cm_buttons, cm_target,
    output cm_start, cm_accepted
  );

  modport slave (
    output in_valid, in_last, in_num_lights, in_num_buttons, in_buttons, in_target,
    output cm_ready, cm_min_presses,
    input  in_ready, cm_num_lights, cm_num_buttons, cm_buttons, cm_target,
    input  cm_start, cm_accepted
  );
endinterface

// File: rtl/machine_scheduler_accumulator.sv
// Saturating press total, sticky overflow and retired/unsolvable machine counters.
module scheduler_accumulator
  import machine_scheduler_pkg::*;
#(
  parameter int unsigned PRESSES_W = 32'd4,
  parameter int unsigned TOTAL_W   = 32'd16,
  parameter int unsigned COUNT_W   = 32'd10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_i,
  input  logic [PRESSES_W-1:0] presses_i,
  output logic [TOTAL_W-1:0]   total_o,
  output logic                 overflow_o,
  output logic [COUNT_W-1:0]   done_cnt_o,
  output logic [COUNT_W-1:0]   unsolv_cnt_o
);

  logic [TOTAL_W-1:0] total_q, total_d;
  logic               overflow_q, overflow_d;
  logic [COUNT_W-1:0] done_q, done_d;
  logic [COUNT_W-1:0] unsolv_q, unsolv_d;

  // An all-ones result means no solution: count it but leave the total alone.
  always_comb begin
    total_d    = total_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    unsolv_d   = unsolv_q;
    if (acc_i) begin
      done_d = done_q + COUNT_W'(1'b1);
      if (&presses_i) begin
        unsolv_d = unsolv_q + COUNT_W'(1'b1);
      end else begin
        total_d    = TOTAL_W'(sat_add(32'(total_q), 32'(presses_i), TOTAL_W));
        overflow_d = overflow_q | sat_hit(32'(total_q), 32'(presses_i), TOTAL_W);
      end
    end else begin
      done_d = done_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= '0;
      unsolv_q   <= '0;
    end else begin
      total_q    <= total_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      unsolv_q   <= unsolv_d;
    end
  end

  assign total_o      = total_q;
  assign overflow_o   = overflow_q;
  assign done_cnt_o   = done_q;
  assign unsolv_cnt_o = unsolv_q;

endmodule

// File: rtl/machine_scheduler.sv
// Feeds machine descriptors one at a time to a configure_machine solver and sums its results.
// Optional solver watchdog enabled by defining MACHINE_SCHEDULER_WATCHDOG_EN.
module machine_scheduler
  import machine_scheduler_pkg::*;
#(
  parameter int unsigned MAX_NUM_LIGHTS    = 32'd10,
  parameter int unsigned MAX_NUM_BUTTONS   = 32'd13,
  parameter int unsigned MAX_NUM_LIGHTS_W  = $clog2(MAX_NUM_LIGHTS + 32'd1),
  parameter int unsigned MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 32'd1),
  parameter int unsigned TOTAL_W           = 32'd16,
  parameter int unsigned COUNT_W           = 32'd10
`ifdef MACHINE_SCHEDULER_WATCHDOG_EN
  , parameter int unsigned WATCHDOG_CYCLES = 32'd4096
`endif
) (
  input  logic               clk,
  input  logic               rst,
  machine_scheduler_if.master bus,
  output logic [TOTAL_W-1:0] total_presses,
  output logic               total_valid,
  output logic [COUNT_W-1:0] machines_done,
  output logic [COUNT_W-1:0] unsolvable_count,
  output logic               overflow
`ifdef MACHINE_SCHEDULER_WATCHDOG_EN
  , output logic             watchdog_err
`endif
);

  localparam int unsigned BTN_BITS = MAX_NUM_BUTTONS * MAX_NUM_LIGHTS;

  state_t                       state_q, state_d;
  logic                         in_ready_q, in_ready_d;
  logic                         cm_start_q, cm_start_d;
  logic                         total_valid_q, total_valid_d;
  logic                         last_q, last_d;
  logic [MAX_NUM_LIGHTS_W-1:0]  num_lights_q, num_lights_d;
  logic [MAX_NUM_BUTTONS_W-1:0] num_buttons_q, num_buttons_d;
  logic [BTN_BITS-1:0]          buttons_q, buttons_d;
  logic [MAX_NUM_LIGHTS-1:0]    target_q, target_d;

  logic                         accept_s;
  logic                         timeout_s;
  logic                         done_s;
  logic [MAX_NUM_BUTTONS_W-1:0] presses_s;

  assign accept_s  = (state_q == IDLE) && bus.in_valid && in_ready_q;
  assign done_s    = (state_q == WAIT) && (bus.cm_ready || timeout_s);
  assign presses_s = bus.cm_ready ? bus.cm_min_presses : {MAX_NUM_BUTTONS_W{1'b1}};

`ifdef MACHINE_SCHEDULER_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 32'd1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;

  assign timeout_s = (state_q == WAIT) && !bus.cm_ready &&
                     (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 32'd1));

  // The counter only advances while the solver is outstanding.
  always_comb begin
    wd_err_d = wd_err_q | timeout_s;
    if ((state_q == WAIT) && !done_s) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1'b1);
    end else begin
      wd_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign watchdog_err = wd_err_q;
`else
  assign timeout_s = 1'b0;
`endif

  // DRAIN swallows the solver's registered ready, which lingers one cycle past accepted.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    num_lights_d  = num_lights_q;
    num_buttons_d = num_buttons_q;
    buttons_d     = buttons_q;
    target_d      = target_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          last_d        = bus.in_last;
          num_lights_d  = bus.in_num_lights;
          num_buttons_d = bus.in_num_buttons;
          buttons_d     = bus.in_buttons;
          target_d      = bus.in_target;
          state_d       = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (done_s) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        if (last_q) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    in_ready_d    = (state_d == IDLE);
    cm_start_d    = (state_d == START);
    total_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      cm_start_q    <= 1'b0;
      total_valid_q <= 1'b0;
      last_q        <= 1'b0;
      num_lights_q  <= '0;
      num_buttons_q <= '0;
      buttons_q     <= '0;
      target_q      <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      cm_start_q    <= cm_start_d;
      total_valid_q <= total_valid_d;
      last_q        <= last_d;
      num_lights_q  <= num_lights_d;
      num_buttons_q <= num_buttons_d;
      buttons_q     <= buttons_d;
      target_q      <= target_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.cm_start       = cm_start_q;
  assign bus.cm_accepted    = done_s;
  assign bus.cm_num_lights  = num_lights_q;
  assign bus.cm_num_buttons = num_buttons_q;
  assign bus.cm_buttons     = buttons_q;
  assign bus.cm_target      = target_q;
  assign total_valid        = total_valid_q;

  scheduler_accumulator #(
    .PRESSES_W (MAX_NUM_BUTTONS_W),
    .TOTAL_W   (TOTAL_W),
    .COUNT_W   (COUNT_W)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .acc_i        (done_s),
    .presses_i    (presses_s),
    .total_o      (total_presses),
    .overflow_o   (overflow),
    .done_cnt_o   (machines_done),
    .unsolv_cnt_o (unsolvable_count)
  );

endmodule

// File: tb/tb_machine_scheduler.sv
// Self-checking bench: a 16-bit-total DUT and a 4-bit-total DUT share identical stimulus.
module tb_machine_scheduler;
  import machine_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  machine_scheduler_if #(.MAX_NUM_LIGHTS(10), .MAX_NUM_BUTTONS(13)) bus ();
  machine_scheduler_if #(.MAX_NUM_LIGHTS(10), .MAX_NUM_BUTTONS(13)) bus_s ();

  logic [15:0] total_presses;
  logic        total_valid, overflow;
  logic [9:0]  machines_done, unsolvable_count;
  logic [3:0]  total_s;
  logic        total_valid_s, overflow_s;
  logic [9:0]  machines_done_s, unsolvable_count_s;
`ifdef MACHINE_SCHEDULER_WATCHDOG_EN
  logic        watchdog_err, watchdog_err_s;
`endif

  machine_scheduler #(
    .TOTAL_W(16), .COUNT_W(10)
`ifdef MACHINE_SCHEDULER_WATCHDOG_EN
    , .WATCHDOG_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .total_presses(total_presses), .total_valid(total_valid),
    .machines_done(machines_done), .unsolvable_count(unsolvable_count),
    .overflow(overflow)
`ifdef MACHINE_SCHEDULER_WATCHDOG_EN
    , .watchdog_err(watchdog_err)
`endif
  );

  machine_scheduler #(
    .TOTAL_W(4), .COUNT_W(10)
`ifdef MACHINE_SCHEDULER_WATCHDOG_EN
    , .WATCHDOG_CYCLES(8)
`endif
  ) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s),
    .total_presses(total_s), .total_valid(total_valid_s),
    .machines_done(machines_done_s), .unsolvable_count(unsolvable_count_s),
    .overflow(overflow_s)
`ifdef MACHINE_SCHEDULER_WATCHDOG_EN
    , .watchdog_err(watchdog_err_s)
`endif
  );

  assign bus_s.in_valid       = bus.in_valid;
  assign bus_s.in_last        = bus.in_last;
  assign bus_s.in_num_lights  = bus.in_num_lights;
  assign bus_s.in_num_buttons = bus.in_num_buttons;
  assign bus_s.in_buttons     = bus.in_buttons;
  assign bus_s.in_target      = bus.in_target;
  assign bus_s.cm_ready       = bus.cm_ready;
  assign bus_s.cm_min_presses = bus.cm_min_presses;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [3:0]   d_nl, d_nb;
  logic [129:0] d_bt;
  logic [9:0]   d_tg;

  task automatic check_zero(input string tag);
    chk({tag, "_total"}, total_presses, 0);
    chk({tag, "_done"}, machines_done, 0);
    chk({tag, "_uns"}, unsolvable_count, 0);
    chk({tag, "_valid"}, total_valid, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_cm_start"}, bus.cm_start, 0);
    chk({tag, "_cm_acc"}, bus.cm_accepted, 0);
    chk({tag, "_cm_desc"}, {bus.cm_num_lights, bus.cm_num_buttons, bus.cm_buttons, bus.cm_target}, 0);
    chk({tag, "_total_s"}, total_s, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.cm_ready = 1'b0;
    #1;
    check_zero("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1);
  endtask

  // Offers a random descriptor; returns at the negedge of the START cycle (ok=0 on timeout).
  task automatic present(input bit last, output bit ok);
    int n;
    d_nl = 4'($urandom_range(1, 10));
    d_nb = 4'($urandom_range(1, 13));
    d_bt = 130'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    d_tg = 10'($urandom());
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_last = last;
    bus.in_num_lights = d_nl;
    bus.in_num_buttons = d_nb;
    bus.in_buttons = d_bt;
    bus.in_target = d_tg;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 100);
    chk("accept_timeout", ok, 1);
    if (ok) begin
      @(negedge clk);
      chk("cm_start", bus.cm_start, 1);
    end
    bus.in_valid = 1'b0;
    bus.in_num_lights = ~d_nl;
    bus.in_buttons = ~d_bt;
    bus.in_target = ~d_tg;
    if (ok) chk("desc_at_start", {bus.cm_num_lights, bus.cm_num_buttons, bus.cm_buttons, bus.cm_target},
                {d_nl, d_nb, d_bt, d_tg});
  endtask

  // Solver model: ready after lat WAIT cycles, held one extra (stale) cycle after accepted.
  task automatic run_machine(input logic [3:0] p, input bit last, input int lat);
    bit ok;
    present(last, ok);
    if (!ok) return;
    repeat (lat) begin
      @(negedge clk);
      chk("no_start_in_wait", bus.cm_start, 0);
      chk("no_early_accept", bus.cm_accepted, 0);
    end
    bus.cm_ready = 1'b1;
    bus.cm_min_presses = p;
    #1;
    chk("cm_accepted", bus.cm_accepted, 1);
    @(negedge clk);
    chk("drain_no_accept", bus.cm_accepted, 0);
    chk("desc_at_drain", {bus.cm_num_lights, bus.cm_num_buttons, bus.cm_buttons, bus.cm_target},
        {d_nl, d_nb, d_bt, d_tg});
    @(negedge clk);
    bus.cm_ready = 1'b0;
    bus.cm_min_presses = 4'($urandom());
  endtask

  typedef struct {
    bit         rst_before;
    logic [3:0] p;
    bit         last;
    int         total;
    int         done;
    int         uns;
    bit         valid;
    int         total4;
    bit         ovf4;
  } vec_t;

  vec_t tbl[6];

  task automatic check_state(input string tag, input int t16, input int dn, input int un,
                             input bit vld, input int t4, input bit o4);
    chk({tag, "_total"}, total_presses, t16);
    chk({tag, "_done"}, machines_done, dn);
    chk({tag, "_uns"}, unsolvable_count, un);
    chk({tag, "_valid"}, total_valid, vld);
    chk({tag, "_in_ready"}, bus.in_ready, !vld);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_total_s"}, total_s, t4);
    chk({tag, "_ovf_s"}, overflow_s, o4);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok;
    int sum, uns, dn;
    logic [3:0] p;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_num_lights = '0;
    bus.in_num_buttons = '0;
    bus.in_buttons = '0;
    bus.in_target = '0;
    bus.cm_ready = 1'b0;
    bus.cm_min_presses = '0;

    tbl[0] = '{1, 4'd2, 0, 2, 1, 0, 0, 2, 0};
    tbl[1] = '{0, 4'd3, 0, 5, 2, 0, 0, 5, 0};
    tbl[2] = '{0, 4'd5, 1, 10, 3, 0, 1, 10, 0};
    tbl[3] = '{1, 4'd9, 0, 9, 1, 0, 0, 9, 0};
    tbl[4] = '{0, NO_SOLUTION, 0, 9, 2, 1, 0, 9, 0};
    tbl[5] = '{0, 4'd9, 1, 18, 3, 1, 1, 15, 1};

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst_before) do_reset();
      run_machine(tbl[i].p, tbl[i].last, $urandom_range(1, 4));
      check_state($sformatf("tbl%0d", i), tbl[i].total, tbl[i].done, tbl[i].uns,
                  tbl[i].valid, tbl[i].total4, tbl[i].ovf4);
    end

    // DONE holds and ignores further descriptors until reset.
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("done_in_ready", bus.in_ready, 0);
      chk("done_no_start", bus.cm_start, 0);
    end
    bus.in_valid = 1'b0;
    check_state("done_hold", 18, 3, 1, 1, 15, 1);

    // Reset while the solver is outstanding.
    do_reset();
    run_machine(4'd4, 0, 2);
    check_state("pre_abort", 4, 1, 0, 0, 4, 0);
    present(0, ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_mid_rst", bus.in_ready, 1);
    run_machine(4'd7, 1, 3);
    check_state("post_abort", 7, 1, 0, 1, 7, 0);

    // Randomized run against a sum/min reference model.
    do_reset();
    sum = 0; uns = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      p = ($urandom_range(0, 5) == 0) ? NO_SOLUTION : 4'($urandom_range(0, 14));
      run_machine(p, i == 39, $urandom_range(1, 6));
      dn++;
      if (p == NO_SOLUTION) uns++;
      else sum += p;
      check_state($sformatf("rnd%0d", i), (sum > 65535) ? 65535 : sum, dn, uns, i == 39,
                  (sum > 15) ? 15 : sum, sum > 15);
    end

`ifdef MACHINE_SCHEDULER_WATCHDOG_EN
    do_reset();
    present(0, ok);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("wd_no_accept", bus.cm_accepted, 0);
    end
    @(negedge clk);
    #1;
    chk("wd_accept", bus.cm_accepted, 1);
    @(negedge clk);
    chk("wd_err", watchdog_err, 1);
    chk("wd_err_s", watchdog_err_s, 1);
    chk("wd_uns", unsolvable_count, 1);
    chk("wd_done", machines_done, 1);
    chk("wd_total", total_presses, 0);
    @(negedge clk);
    chk("wd_in_ready", bus.in_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/machine_scheduler.md
Name: machine_scheduler

Overview:
- Sequencer that feeds a stream of Day 10 machine descriptors, one at a time, into a single configure_machine solver instance.
- Latches each descriptor and drives the solver's start/ready/accepted handshake.
- Sums each machine's min_button_presses into a running puzzle total. Flags machines that have no solution.
- Sits between the input parser stream and the final answer register.

Parameters:
- MAX_NUM_LIGHTS, 10, max lights per machine; sets the row count.
- MAX_NUM_BUTTONS, 13, max buttons per machine.
- MAX_NUM_LIGHTS_W, clog2(MAX_NUM_LIGHTS+1), width of the light count.
- MAX_NUM_BUTTONS_W, clog2(MAX_NUM_BUTTONS+1), width of the button count. Also the presses width.
- TOTAL_W, 16, width of the accumulated total.
- COUNT_W, 10, width of the machine counters.
- WATCHDOG_CYCLES, 4096, solver timeout. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  scheduler can accept a descriptor.
- in_last  in  1  marks the final machine of the puzzle.
- in_num_lights  in  MAX_NUM_LIGHTS_W  number of lights in use.
- in_num_buttons  in  MAX_NUM_BUTTONS_W  number of buttons in use.
- in_buttons  in  MAX_NUM_BUTTONS*MAX_NUM_LIGHTS  per-button light masks; button b occupies bits [b*L +: L].
- in_target  in  MAX_NUM_LIGHTS  target light arrangement.
- cm_num_lights / cm_num_buttons / cm_buttons / cm_target  out  same widths  latched descriptor driven to the solver.
- cm_start  out  1  solver start pulse.
- cm_ready  in  1  solver result valid.
- cm_accepted  out  1  solver result consumed.
- cm_min_presses  in  MAX_NUM_BUTTONS_W  solver result.
- total_presses  out  TOTAL_W  running sum.
- total_valid  out  1  high once the last machine has been summed.
- machines_done  out  COUNT_W  machines retired.
- unsolvable_count  out  COUNT_W  machines whose result was all-ones.
- overflow  out  1  sticky; total saturated.

Behaviour:

Reset (async, rst=1):
- State IDLE.
- All outputs 0; cm_* descriptor registers 0.

States and transitions:
- IDLE:
  - in_ready=1.
  - On in_valid: latch the descriptor and in_last into the last_q register, go to START.
  - in_valid while in_ready=0 is held by the producer (standard valid/ready).
- START:
  - cm_start=1 for exactly 1 cycle.
  - Next state: WAIT.
- WAIT:
  - Wait for cm_ready.
  - When cm_ready=1: cm_accepted=1 (combinational, same cycle), accumulate, go to DRAIN.
- DRAIN:
  - Exactly 1 cycle; cm_ready is ignored.
  - Required because the solver's ready is registered and stays high one cycle after accepted.
  - Next state: DONE if last_q, else IDLE.
- DONE:
  - total_valid=1; in_ready=0.
  - Hold here until rst. A new puzzle requires reset.

Descriptor hold:
- cm_* descriptor outputs stay stable from START through DRAIN.

Accumulation (registered on the WAIT/cm_ready cycle):
- machines_done += 1.
- If cm_min_presses is all-ones: unsolvable_count += 1; total is unchanged.
- Else: total_presses += zero-extended cm_min_presses, saturating at 2^TOTAL_W-1; set overflow on saturation.
- Counters wrap at 2^COUNT_W.

Latency and boundaries:
- Minimum descriptor-to-descriptor latency = solver latency + 4 cycles.
- in_last on the first descriptor: a single-machine puzzle; DONE after one result.
- Reset mid-operation: return to IDLE immediately. The solver must be reset by the same rst tree.
- cm_ready in START is impossible by construction; it is ignored there.

Optional Feature:
- Macro: MACHINE_SCHEDULER_WATCHDOG_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If WATCHDOG_CYCLES elapse without cm_ready: assert sticky output port watchdog_err (1 bit, reset 0).
  - Count the machine as unsolvable, pulse cm_accepted, and go to DRAIN.
- When undefined: no port, no counter; WAIT waits indefinitely.

Decomposition:
- Package machine_scheduler_pkg holds:
  - state_t enum {IDLE, START, WAIT, DRAIN, DONE}.
  - localparam NO_SOLUTION (all-ones presses).
  - sat_add function.
- One sub-module is natural: scheduler_accumulator. It holds the saturating total, the overflow flag and both counters; inputs are accumulate strobe and presses.
- The FSM and descriptor latch stay in the top.

Test Plan:
- Three machines, solver model returns 2, 3, 5 with in_last on the third -> total_presses=10, machines_done=3, total_valid=1, unsolvable_count=0.
- Second of three results = 4'b1111 (NO_SOLUTION) -> unsolvable_count=1, total_presses equals the sum of the other two.
- Solver holds cm_ready one extra cycle after cm_accepted -> counted exactly once; DRAIN absorbs the stale ready.
- TOTAL_W=4, results 9 then 9 -> total_presses=15, overflow=1.
- rst asserted while in WAIT -> all outputs 0 the same cycle, in_ready=1 after release; the next descriptor is accepted.
- With MACHINE_SCHEDULER_WATCHDOG_EN, WATCHDOG_CYCLES=8, solver never responds -> watchdog_err=1 after 8 WAIT cycles, unsolvable_count=1, returns to IDLE.
